// File: rtl/vgg_pkg.sv
// Shared float helpers and result types
// for the sigmoid result collector.
package vgg_pkg;

   localparam logic [31:0] FLOAT_HALF = 32'h3F000000;

   // Entry layout at the default 16-bit index width.
   typedef struct packed {
      logic [31:0] prob;
      logic        cls;
      logic [15:0] idx;
   } result_t;

   function automatic logic f_sign(input logic [31:0] f);
      return f[31];
   endfunction

   function automatic logic [7:0] f_exp(input logic [31:0] f);
      return f[30:23];
   endfunction

   function automatic logic [22:0] f_mant(input logic [31:0] f);
      return f[22:0];
   endfunction

   function automatic logic is_nan(input logic [31:0] f);
      return (f_exp(f) == 8'hFF) && (f_mant(f) != 23'd0);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers.
// Caller is responsible for not overfilling.
module sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] dout
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout  = mem[rd_ptr[AW-1:0]];

   // Pointer advance; reset empties the queue.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; contents need no reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/sigmoid_result_collector.sv
// Classifies sigmoid outputs, tags them with a
// sequence index, queues them and keeps stats.
module sigmoid_result_collector
   import vgg_pkg::*;
#(
   parameter int          DEPTH  = 8,
   parameter int          IDX_W  = 16,
   parameter logic [31:0] THRESH = FLOAT_HALF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_in,
   input  logic [31:0]      f_x,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_prob,
   output logic             out_class,
   output logic [IDX_W-1:0] out_index,
   input  logic             stats_clr,
   output logic [IDX_W-1:0] cnt_total,
   output logic [IDX_W-1:0] cnt_class1,
   output logic             overflow,
   output logic             nan_seen
);

   localparam int W = 33 + IDX_W;

   logic             nan_in;
   logic             cls_in;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             drop;
   logic [W-1:0]     head;
   logic [31:0]      hd_prob;
   logic             hd_cls;
   logic [IDX_W-1:0] hd_idx;
   logic [IDX_W-1:0] seq_idx;
   logic [IDX_W-1:0] tot_base;
   logic [IDX_W-1:0] c1_base;
   logic [IDX_W-1:0] tot_nxt;
   logic [IDX_W-1:0] c1_nxt;

   // Threshold classification; negatives and NaN are class 0.
   always_comb begin
      nan_in = is_nan(f_x);
      cls_in = 1'b0;
      if (!nan_in && !f_sign(f_x))
         cls_in = (f_x[30:0] >= THRESH[30:0]);
   end

   assign out_valid = !empty;
   assign pop       = out_valid && out_ready;
   assign push      = valid_in && (!full || pop);
   assign drop      = valid_in && full && !pop;

   sync_fifo #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   ({f_x, cls_in, seq_idx}),
      .full  (full),
      .empty (empty),
      .dout  (head)
   );

   assign {hd_prob, hd_cls, hd_idx} = head;
   assign out_prob  = empty ? 32'd0 : hd_prob;
   assign out_class = empty ? 1'b0 : hd_cls;
   assign out_index = empty ? '0 : hd_idx;

   // Clear applies first, then the new sample counts, saturating.
   always_comb begin
      tot_base = stats_clr ? '0 : cnt_total;
      c1_base  = stats_clr ? '0 : cnt_class1;
      tot_nxt  = tot_base;
      c1_nxt   = c1_base;
      if (push && !(&tot_base))
         tot_nxt = tot_base + 1'b1;
      if (push && cls_in && !(&c1_base))
         c1_nxt = c1_base + 1'b1;
   end

   // Sequence index advances on every sample, kept or dropped.
   always_ff @(posedge clk) begin
      if (reset)         seq_idx <= '0;
      else if (valid_in) seq_idx <= seq_idx + 1'b1;
   end

   // Statistics counters and sticky flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_total  <= '0;
         cnt_class1 <= '0;
         overflow   <= 1'b0;
         nan_seen   <= 1'b0;
      end else begin
         cnt_total  <= tot_nxt;
         cnt_class1 <= c1_nxt;
         overflow   <= (overflow & !stats_clr) | drop;
         nan_seen   <= (nan_seen & !stats_clr) | (valid_in & nan_in);
      end
   end

endmodule
